// File: rtl/eclk_interval_timer.sv
// 8520-style 16-bit interval timer counting E-clock (or cascaded) ticks in the clk_28 domain.
// Provides a CPU register port, a one-cycle underflow pulse and a sticky interrupt flag.
module eclk_interval_timer #(
  parameter logic [15:0] LATCH_RST = 16'hFFFF,
  parameter bit          IRQ_PRIO  = 1'b1
) (
  input  logic       clk_28,
  input  logic       reset_n,
  input  logic       clk7_en,
  input  logic       eclk_en,
  input  logic       cnt_en,
  input  logic       wr_en,
  input  logic [1:0] addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  input  logic       irq_ack,
  output logic       tmr_uf,
  output logic       irq
);

  localparam logic [1:0] ADDR_LO   = 2'd0;
  localparam logic [1:0] ADDR_HI   = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  localparam int BIT_START   = 0;
  localparam int BIT_ONESHOT = 3;
  localparam int BIT_LOAD    = 4;
  localparam int BIT_INMODE  = 5;

  logic [15:0] latch;
  logic [15:0] counter;
  logic        start;
  logic        oneshot;
  logic        inmode;

  logic        wr_lo;
  logic        wr_hi;
  logic        wr_ctrl;
  logic        force_load;
  logic        hi_load;
  logic        tick;
  logic        underflow;
  logic        ack;

  // Decode of this clk7_en cycle's activity; loads pre-empt the tick entirely.
  always_comb begin
    wr_lo      = clk7_en & wr_en & (addr == ADDR_LO);
    wr_hi      = clk7_en & wr_en & (addr == ADDR_HI);
    wr_ctrl    = clk7_en & wr_en & (addr == ADDR_CTRL);
    force_load = wr_ctrl & wr_data[BIT_LOAD];
    hi_load    = wr_hi & ~start;
    tick       = clk7_en & start & (inmode ? cnt_en : eclk_en);
    underflow  = tick & ~force_load & ~hi_load & (counter == 16'h0000);
    ack        = clk7_en & irq_ack;
  end

  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      latch <= LATCH_RST;
    end else begin
      if (wr_lo) latch[7:0]  <= wr_data;
      if (wr_hi) latch[15:8] <= wr_data;
    end
  end

  // A hi-latch load uses the low byte as it stood before this cycle.
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      counter <= LATCH_RST;
    end else if (force_load) begin
      counter <= latch;
    end else if (hi_load) begin
      counter <= {wr_data, latch[7:0]};
    end else if (tick) begin
      counter <= underflow ? latch : (counter - 16'd1);
    end
  end

  // A control write overrides both the one-shot stop and the hi-write auto-start.
  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      start   <= 1'b0;
      oneshot <= 1'b0;
      inmode  <= 1'b0;
    end else if (wr_ctrl) begin
      start   <= wr_data[BIT_START];
      oneshot <= wr_data[BIT_ONESHOT];
      inmode  <= wr_data[BIT_INMODE];
    end else if (underflow && oneshot) begin
      start <= 1'b0;
    end else if (hi_load && oneshot) begin
      start <= 1'b1;
    end
  end

  always_ff @(posedge clk_28 or negedge reset_n) begin
    if (!reset_n) begin
      tmr_uf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      tmr_uf <= underflow;
      if (underflow && (IRQ_PRIO || !ack)) begin
        irq <= 1'b1;
      end else if (ack) begin
        irq <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_LO:   rd_data = counter[7:0];
      ADDR_HI:   rd_data = counter[15:8];
      ADDR_CTRL: rd_data = {2'b00, inmode, 1'b0, oneshot, 2'b00, start};
      default:   rd_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_eclk_interval_timer.sv
// Bench for eclk_interval_timer: directed scenarios then random traffic, all checked
// against an arithmetic reference model of the timer.
module tb_eclk_interval_timer;

  logic       clk_28;
  logic       reset_n;
  logic       clk7_en;
  logic       eclk_en;
  logic       cnt_en;
  logic       wr_en;
  logic [1:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       irq_ack;
  logic       tmr_uf;
  logic       irq;

  int tests;
  int fails;
  int uf_cnt;

  // reference model state
  int m_latch, m_cnt, m_start, m_oneshot, m_inmode, m_irq, m_uf;

  eclk_interval_timer dut (
    .clk_28  (clk_28),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .eclk_en (eclk_en),
    .cnt_en  (cnt_en),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq_ack (irq_ack),
    .tmr_uf  (tmr_uf),
    .irq     (irq)
  );

  initial clk_28 = 1'b0;
  always #5 clk_28 = ~clk_28;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic model_reset();
    m_latch = 65535; m_cnt = 65535;
    m_start = 0; m_oneshot = 0; m_inmode = 0;
    m_irq = 0; m_uf = 0;
  endtask

  // One clk_28 edge of the timer rules, IRQ_PRIO=1.
  task automatic model_step(input logic c7, e, c, w, input logic [1:0] a,
                            input logic [7:0] d, input logic ack);
    int tick, uf, reloaded;
    uf = 0;
    if (c7) begin
      tick = (m_start != 0) && ((m_inmode != 0) ? c : e);
      reloaded = 0;
      if (w && a == 2 && d[4]) begin
        m_cnt = m_latch; reloaded = 1;
      end else if (w && a == 1 && m_start == 0) begin
        m_cnt = d * 256 + m_latch % 256; reloaded = 1;
      end
      if (tick != 0 && reloaded == 0) begin
        if (m_cnt == 0) begin uf = 1; m_cnt = m_latch; end
        else m_cnt = m_cnt - 1;
      end
      if (w && a == 2) begin
        m_start = d[0]; m_oneshot = d[3]; m_inmode = d[5];
      end else if (uf != 0 && m_oneshot != 0) begin
        m_start = 0;
      end else if (w && a == 1 && m_start == 0 && m_oneshot != 0) begin
        m_start = 1;
      end
      if (w && a == 0) m_latch = (m_latch / 256) * 256 + d;
      if (w && a == 1) m_latch = d * 256 + m_latch % 256;
      if (uf != 0) m_irq = 1;
      else if (ack) m_irq = 0;
    end
    m_uf = uf;
  endtask

  task automatic check_all();
    logic [7:0] v;
    chk("tmr_uf", {15'd0, tmr_uf}, m_uf[15:0]);
    chk("irq", {15'd0, irq}, m_irq[15:0]);
    if (tmr_uf === 1'b1) uf_cnt++;
    rd(2'd0, v); chk("cnt_lo", {8'd0, v}, 16'(m_cnt % 256));
    rd(2'd1, v); chk("cnt_hi", {8'd0, v}, 16'(m_cnt / 256));
    rd(2'd2, v); chk("ctrl", {8'd0, v}, 16'(m_inmode * 32 + m_oneshot * 8 + m_start));
    rd(2'd3, v); chk("rsvd", {8'd0, v}, 16'h0000);
  endtask

  task automatic step(input logic c7, e, c, w, input logic [1:0] a,
                      input logic [7:0] d, input logic ack);
    clk7_en = c7; eclk_en = e; cnt_en = c; wr_en = w;
    addr = a; wr_data = d; irq_ack = ack;
    @(posedge clk_28);
    model_step(c7, e, c, w, a, d, ack);
    #1;
    clk7_en = 1'b0; eclk_en = 1'b0; cnt_en = 1'b0; wr_en = 1'b0; irq_ack = 1'b0;
    check_all();
  endtask

  // Non-enable cycles carry stray pulses that must be ignored.
  task automatic idle3();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h11, 1'b1);
  endtask

  task automatic w7(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b1, a, d, 1'b0);
    idle3();
  endtask

  task automatic tk(input logic e, c, ack);
    step(1'b1, e, c, 1'b0, 2'd0, 8'h00, ack);
    idle3();
  endtask

  task automatic check_reset(input string tag);
    logic [7:0] v;
    chk({tag, "_uf"}, {15'd0, tmr_uf}, 16'd0);
    chk({tag, "_irq"}, {15'd0, irq}, 16'd0);
    rd(2'd1, v); chk({tag, "_hi"}, {8'd0, v}, 16'h00FF);
    rd(2'd0, v); chk({tag, "_lo"}, {8'd0, v}, 16'h00FF);
    rd(2'd2, v); chk({tag, "_ctrl"}, {8'd0, v}, 16'h0000);
  endtask

  initial begin
    logic [7:0] v;
    tests = 0; fails = 0; uf_cnt = 0;
    reset_n = 1'b0;
    clk7_en = 0; eclk_en = 0; cnt_en = 0; wr_en = 0; addr = 0; wr_data = 0; irq_ack = 0;
    model_reset();
    #22;
    check_reset("rst");
    @(negedge clk_28);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);

    // continuous mode, period 4 ticks
    w7(2'd0, 8'h03); w7(2'd1, 8'h00); w7(2'd2, 8'h01);
    uf_cnt = 0;
    for (int i = 0; i < 12; i++) tk(1'b1, 1'b0, 1'b0);
    chk("cont_uf_count", 16'(uf_cnt), 16'd3);
    chk("cont_irq", {15'd0, irq}, 16'd1);
    rd(2'd0, v); chk("cont_cnt", {8'd0, v}, 16'h0003);

    // ack coincident with underflow, then lone ack
    for (int i = 0; i < 3; i++) tk(1'b1, 1'b0, 1'b0);
    tk(1'b1, 1'b0, 1'b1);
    chk("ack_uf_irq", {15'd0, irq}, 16'd1);
    tk(1'b0, 1'b0, 1'b1);
    chk("ack_lone_irq", {15'd0, irq}, 16'd0);

    // one-shot auto-start
    w7(2'd2, 8'h08); w7(2'd0, 8'h02); w7(2'd1, 8'h00);
    rd(2'd2, v); chk("os_autostart", {8'd0, v}, 16'h0009);
    uf_cnt = 0;
    for (int i = 0; i < 6; i++) tk(1'b1, 1'b0, 1'b0);
    chk("os_uf_count", 16'(uf_cnt), 16'd1);
    rd(2'd2, v); chk("os_stopped", {8'd0, v}, 16'h0008);
    rd(2'd0, v); chk("os_cnt", {8'd0, v}, 16'h0002);

    // force load coincident with a tick
    w7(2'd2, 8'h00); w7(2'd0, 8'h10); w7(2'd1, 8'h00);
    w7(2'd2, 8'h01); w7(2'd0, 8'h00); w7(2'd1, 8'h01);
    step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'h11, 1'b0);
    rd(2'd1, v); chk("fl_cnt_hi", {8'd0, v}, 16'h0001);
    rd(2'd0, v); chk("fl_cnt_lo", {8'd0, v}, 16'h0000);
    rd(2'd2, v); chk("fl_ctrl", {8'd0, v}, 16'h0001);
    idle3();

    // cascade: count cnt_en only
    w7(2'd2, 8'h00); w7(2'd0, 8'h01); w7(2'd1, 8'h00); w7(2'd2, 8'h21);
    uf_cnt = 0;
    for (int i = 0; i < 30; i++) tk(1'b1, (i % 5) == 4, 1'b0);
    chk("casc_uf_count", 16'(uf_cnt), 16'd3);

    // reset mid-count while tmr_uf is high
    w7(2'd2, 8'h00); w7(2'd0, 8'h01); w7(2'd1, 8'h00); w7(2'd2, 8'h01);
    tk(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    chk("pre_rst_uf", {15'd0, tmr_uf}, 16'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset("async_rst");
    @(posedge clk_28);
    #1;
    check_reset("held_rst");
    @(negedge clk_28);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic c7, e, c, w, ack;
      logic [1:0] a;
      logic [7:0] d;
      c7  = ($urandom_range(0, 3) == 0);
      e   = ($urandom_range(0, 1) == 0);
      c   = ($urandom_range(0, 2) == 0);
      w   = ($urandom_range(0, 7) == 0);
      ack = ($urandom_range(0, 9) == 0);
      a   = 2'($urandom_range(0, 3));
      case (a)
        2'd0:    d = 8'($urandom_range(0, 15));
        2'd1:    d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
        default: d = 8'($urandom_range(0, 255));
      endcase
      if (a == 2'd2 && m_cnt == 0) w = 1'b0;
      step(c7, e, c, w, a, d, ack);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
